// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction memory request/response, decode handoff, redirect and halt status.
// No latency of its own; it only carries signals between the fetch unit and its neighbours.
// Backpressure is carried by imem_req_ready (memory side) and inst_ready (decode side).
interface instr_fetch_unit_if;
  // Instruction memory request channel
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  // Instruction memory response channel (one word per accepted request)
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  // Decode handoff
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  // Control flow change and status
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_halted;

  // Fetch unit side
  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_halted
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc,
    input  fetch_halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: word-aligned PC, one outstanding imem read, small FIFO of {pc, word} for decode.
// Latency: a response captured at edge N is on inst_* after edge N; one fetch per 2 cycles at best.
// Backpressure: requests only issue when FIFO entries + outstanding < FIFO_DEPTH, so no response is dropped.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128,
  parameter int          FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // Fetch control state
  state_t      r_state;
  logic [31:0] r_pc;        // address of the next request
  logic [31:0] r_req_pc;    // address of the request currently in flight
  logic        r_discard;   // in-flight response belongs to a flushed path

  // Instruction buffer
  logic [31:0]   r_fifo_pc  [FIFO_DEPTH];
  logic [31:0]   r_fifo_dat [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Combinational helpers
  logic [31:0] w_redirect_pc;
  logic [32:0] w_pc_plus4_ext;
  logic        w_at_end;
  logic        w_outstanding;
  logic        w_credit;
  logic        w_req_vld;
  logic        w_req_fire;
  logic        w_rsp_take;
  logic        w_push;
  logic        w_inst_vld;
  logic        w_pop;

  // Low address bits of a redirect target are meaningless for word fetch
  assign w_redirect_pc  = bus.redirect_pc & 32'hFFFF_FFFC;

  // 33-bit end check so a PC near 2^32 cannot wrap back into range
  assign w_pc_plus4_ext = {1'b0, r_pc} + 33'd4;
  assign w_at_end       = w_pc_plus4_ext > 33'(IMEM_BYTES);

  // One request at most in flight; it is outstanding exactly while waiting for its word
  assign w_outstanding  = (r_state == S_WAIT);
  assign w_credit       = (r_count + CW'(w_outstanding)) < CW'(FIFO_DEPTH);

  assign w_req_vld      = !reset && (r_state == S_REQ) && w_credit && !w_at_end;
  assign w_req_fire     = w_req_vld && bus.imem_req_ready;

  // A redirect flushes the buffer, so neither a push nor a pop survives that cycle
  assign w_rsp_take     = (r_state == S_WAIT) && bus.imem_rsp_valid;
  assign w_push         = w_rsp_take && !r_discard && !bus.redirect_valid;
  assign w_inst_vld     = !reset && (r_count != '0);
  assign w_pop          = w_inst_vld && bus.inst_ready && !bus.redirect_valid;

  // Outputs come from registered state only and are forced quiet while in reset
  assign bus.imem_req_valid = w_req_vld;
  assign bus.imem_req_addr  = reset ? 32'h0 : r_pc;
  assign bus.inst_valid     = w_inst_vld;
  assign bus.inst_data      = w_inst_vld ? r_fifo_dat[r_rptr] : 32'h0;
  assign bus.inst_pc        = w_inst_vld ? r_fifo_pc[r_rptr]  : 32'h0;
  assign bus.fetch_halted   = !reset && (r_state == S_HALT);

  // Fetch FSM: request sequencing, PC advance, redirect and end-of-memory halt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_req_pc  <= RESET_PC;
      r_discard <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc <= w_redirect_pc;
      // Old request still owes a word: wait for it and throw it away
      if (w_req_fire || ((r_state == S_WAIT) && !bus.imem_rsp_valid)) begin
        r_state   <= S_WAIT;
        r_discard <= 1'b1;
      end else begin
        r_state   <= S_REQ;
        r_discard <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (w_req_fire) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + 32'd4;
            r_state  <= S_WAIT;
          end else if (w_at_end) begin
            r_state <= S_HALT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            r_discard <= 1'b0;
            r_state   <= S_REQ;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Buffer storage: written only on an accepted, non-discarded response
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]  <= r_req_pc;
      r_fifo_dat[r_wptr] <= bus.imem_rsp_data;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer outright
  always_ff @(posedge clk) begin
    if (reset || bus.redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
